// File: rtl/fpga_pkg.sv
// fpga_pkg: shared word width, checker state encoding and counter width helper
package fpga_pkg;
   localparam int MemoryElementWidth = 12;
   localparam int DefaultDepth = 2000;
   typedef enum logic [1:0] {RUN, DRAIN, DONE} outChkState_t;
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction
endpackage

// File: rtl/out_channel_fifo.sv
// out_channel_fifo: circular buffer with registered full/valid flags and a first-word-fall-through head register
module out_channel_fifo
   import fpga_pkg::*;
#(
   parameter int W = MemoryElementWidth,
   parameter int N = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic         full,
   output logic         valid,
   output logic [W-1:0] rdata
);
   localparam int PW = $clog2(N);
   localparam int CW = cnt_width(N);
   logic [W-1:0] mem [N];
   logic [PW-1:0] wptr, rptr, rptr_n;
   logic [CW-1:0] cnt, cnt_n;
   // next read pointer and occupancy; the head word is prefetched from these
   always_comb begin
      rptr_n = pop ? (rptr == PW'(N - 1) ? '0 : rptr + 1'b1) : rptr;
      cnt_n = cnt + CW'(push) - CW'(pop);
   end
   // storage array carries no reset; occupancy decides what is valid
   always_ff @(posedge clock) begin
      if (push) mem[wptr] <= wdata;
   end
   // pointers, occupancy, flags and head word; a push into an otherwise-empty slot bypasses the array
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wptr <= '0;
         rptr <= '0;
         cnt <= '0;
         full <= 1'b0;
         valid <= 1'b0;
         rdata <= '0;
      end else begin
         wptr <= push ? (wptr == PW'(N - 1) ? '0 : wptr + 1'b1) : wptr;
         rptr <= rptr_n;
         cnt <= cnt_n;
         full <= cnt_n == CW'(N);
         valid <= cnt_n != '0;
         rdata <= cnt_n == '0 ? rdata : (push && cnt == CW'(pop)) ? wdata : mem[rptr_n];
      end
   end
endmodule

// File: rtl/out_channel_checker.sv
// out_channel_checker: buffers executor out words, streams them to a consumer and checks them against an expected list
module out_channel_checker
   import fpga_pkg::*;
#(
   parameter int NOut = DefaultDepth,
   parameter int NExpect = DefaultDepth
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          outWrite,
   input  logic [MemoryElementWidth-1:0] outWord,
   output logic                          outFull,
   input  logic                          programDone,
   input  logic                          expectWrite,
   input  logic [MemoryElementWidth-1:0] expectData,
   output logic                          outValid,
   output logic [MemoryElementWidth-1:0] outData,
   input  logic                          outReady,
   output logic                          overflow,
   output logic                          finished,
   output logic                          success
);
   localparam int EW = cnt_width(NExpect);
   localparam int AW = (NExpect > 1) ? $clog2(NExpect) : 1;
   outChkState_t state, state_n;
   logic push, pop, exp_wr, enter_done, bad_word;
   logic mismatch;
   logic [EW-1:0] expect_cnt, pop_cnt;
   logic [MemoryElementWidth-1:0] exp_mem [NExpect];
   out_channel_fifo #(.W(MemoryElementWidth), .N(NOut)) u_fifo (
      .clock(clock),
      .reset(reset),
      .push(push),
      .pop(pop),
      .wdata(outWord),
      .full(outFull),
      .valid(outValid),
      .rdata(outData)
   );
   // next state and handshake qualifiers; DRAIN waits until no word is stored or arriving
   always_comb begin
      push = outWrite && !outFull && state != DONE;
      pop = outValid && outReady;
      exp_wr = expectWrite && state == RUN && expect_cnt != EW'(NExpect);
      state_n = state == RUN ? (programDone ? DRAIN : RUN) :
                state == DRAIN ? (!outValid && !push ? DONE : DRAIN) : DONE;
      enter_done = state == DRAIN && state_n == DONE;
      bad_word = pop_cnt >= expect_cnt || exp_mem[pop_cnt[AW-1:0]] != outData;
   end
   // expected words survive reset; expect_cnt alone marks them valid
   always_ff @(posedge clock) begin
      if (exp_wr) exp_mem[expect_cnt[AW-1:0]] <= expectData;
   end
   // state, sticky error flags, counters and the verdict latched on entry to DONE
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= RUN;
         overflow <= 1'b0;
         mismatch <= 1'b0;
         expect_cnt <= '0;
         pop_cnt <= '0;
         finished <= 1'b0;
         success <= 1'b0;
      end else begin
         state <= state_n;
         overflow <= overflow || (outWrite && (outFull || state == DONE));
         mismatch <= mismatch || (pop && bad_word);
         expect_cnt <= exp_wr ? expect_cnt + 1'b1 : expect_cnt;
         pop_cnt <= (pop && pop_cnt != '1) ? pop_cnt + 1'b1 : pop_cnt;
         finished <= finished || enter_done;
         success <= enter_done ? (!mismatch && !overflow && pop_cnt == expect_cnt) : success;
      end
   end
endmodule

// File: tb/tb_out_channel_checker.sv
// tb_out_channel_checker: directed self-checking bench for out_channel_checker
module tb_out_channel_checker;
   logic clock, reset, outWrite, programDone, expectWrite, outReady;
   logic [11:0] outWord, expectData, outData;
   logic outFull, outValid, overflow, finished, success;
   int checks = 0;
   int errors = 0;
   out_channel_checker #(.NOut(4), .NExpect(32)) dut (
      .clock(clock),
      .reset(reset),
      .outWrite(outWrite),
      .outWord(outWord),
      .outFull(outFull),
      .programDone(programDone),
      .expectWrite(expectWrite),
      .expectData(expectData),
      .outValid(outValid),
      .outData(outData),
      .outReady(outReady),
      .overflow(overflow),
      .finished(finished),
      .success(success)
   );
   initial clock = 1'b0;
   always #5 clock = ~clock;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clock);
      #1;
   endtask
   task automatic do_reset();
      outWrite = 0; programDone = 0; expectWrite = 0; outReady = 0;
      reset = 0;
      step();
      reset = 1;
   endtask
   task automatic exp_w(input logic [11:0] v);
      expectWrite = 1; expectData = v;
      step();
      expectWrite = 0;
   endtask
   task automatic push_w(input logic [11:0] v);
      outWrite = 1; outWord = v;
      step();
      outWrite = 0;
   endtask
   task automatic done_pulse();
      programDone = 1;
      step();
      programDone = 0;
   endtask
   task automatic wait_fin(input string tag);
      int n = 0;
      while (!finished && n < 50) begin
         step();
         n++;
      end
      chk({tag, "_finished"}, finished, 1);
   endtask
   initial begin
      int tx, rx;
      reset = 0; outWrite = 0; outWord = 0; programDone = 0;
      expectWrite = 0; expectData = 0; outReady = 0;
      step(); step();
      chk("rst_full", outFull, 0);
      chk("rst_valid", outValid, 0);
      chk("rst_data", outData, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_fin", finished, 0);
      chk("rst_succ", success, 0);
      reset = 1;
      // empty program: DRAIN after first edge, DONE after the second
      programDone = 1;
      step();
      programDone = 0;
      chk("empty_fin_n", finished, 0);
      step();
      chk("empty_fin_n1", finished, 1);
      chk("empty_succ", success, 1);
      // single matching word
      do_reset();
      exp_w(2);
      outReady = 1;
      push_w(2);
      chk("single_valid", outValid, 1);
      chk("single_data", outData, 2);
      done_pulse();
      chk("single_valid_gone", outValid, 0);
      wait_fin("single");
      chk("single_succ", success, 1);
      chk("single_ovf", overflow, 0);
      // data mismatch
      do_reset();
      exp_w(2);
      outReady = 1;
      push_w(1);
      done_pulse();
      wait_fin("mism");
      chk("mism_succ", success, 0);
      // fewer words than expected
      do_reset();
      exp_w(1); exp_w(2);
      outReady = 1;
      push_w(1);
      done_pulse();
      wait_fin("short");
      chk("short_succ", success, 0);
      // extra word beyond expected list
      do_reset();
      exp_w(1);
      outReady = 1;
      push_w(1); push_w(1);
      done_pulse();
      wait_fin("extra");
      chk("extra_succ", success, 0);
      // backpressure fills the FIFO, fifth push dropped
      do_reset();
      for (int i = 10; i < 14; i++) exp_w(12'(i));
      push_w(10); push_w(11); push_w(12);
      chk("bp_notfull", outFull, 0);
      push_w(13);
      chk("bp_full", outFull, 1);
      chk("bp_ovf_pre", overflow, 0);
      push_w(14);
      chk("bp_ovf", overflow, 1);
      chk("bp_hold", outData, 10);
      outReady = 1;
      for (int i = 0; i < 4; i++) begin
         chk("bp_v", outValid, 1);
         chk("bp_d", outData, 32'(10 + i));
         step();
      end
      chk("bp_empty", outValid, 0);
      chk("bp_notfull2", outFull, 0);
      done_pulse();
      wait_fin("bp");
      chk("bp_succ", success, 0);
      // wrap with simultaneous push/pop and toggling ready
      do_reset();
      for (int i = 0; i < 20; i++) exp_w(12'(i));
      tx = 0; rx = 0;
      for (int c = 0; c < 200 && rx < 20; c++) begin
         outReady = c[0];
         outWrite = tx < 20 && !outFull;
         outWord = 12'(tx);
         if (outValid && outReady) begin
            chk("wrap_d", outData, 32'(rx));
            rx++;
         end
         if (outWrite) tx++;
         step();
      end
      outWrite = 0;
      chk("wrap_rx", 32'(rx), 20);
      chk("wrap_ovf", overflow, 0);
      done_pulse();
      wait_fin("wrap");
      chk("wrap_succ", success, 1);
      // asynchronous reset mid-stream
      do_reset();
      outReady = 0;
      push_w(5); push_w(6); push_w(7);
      chk("mid_valid_pre", outValid, 1);
      reset = 0;
      #1;
      chk("mid_valid", outValid, 0);
      chk("mid_fin", finished, 0);
      chk("mid_ovf", overflow, 0);
      step();
      reset = 1;
      exp_w(9);
      outReady = 1;
      push_w(9);
      chk("post_data", outData, 9);
      done_pulse();
      wait_fin("post");
      chk("post_succ", success, 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
